// File: rtl/reg_alu_pkg.sv
// rtl/reg_alu_pkg.sv - control-word layout, op codes and sequencer states for reg_alu
package reg_alu_pkg;

   localparam int AW_DEF = 3;
   localparam int DW_DEF = 8;
   localparam int RA_DEF = 3;

   typedef enum logic [1:0] {
      OP_0 = 2'b00,
      OP_1 = 2'b01,
      OP_2 = 2'b10,
      OP_3 = 2'b11
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_e;

   // Word layout, MSB-first: sel, wr, op[1:0], rd_addr_a, rd_addr_b, wr_addr, d_in
   function automatic int iw_of(input int ra, input int dw);
      return 4 + 3 * ra + dw;
   endfunction

   function automatic int sel_pos(input int ra, input int dw);
      return iw_of(ra, dw) - 1;
   endfunction

   function automatic int wr_pos(input int ra, input int dw);
      return iw_of(ra, dw) - 2;
   endfunction

   function automatic int op_lsb(input int ra, input int dw);
      return iw_of(ra, dw) - 4;
   endfunction

   function automatic int rda_lsb(input int ra, input int dw);
      return dw + 2 * ra;
   endfunction

   function automatic int rdb_lsb(input int ra, input int dw);
      return dw + ra;
   endfunction

   function automatic int wa_lsb(input int dw);
      return dw;
   endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// rtl/seq_prog_mem.sv - program store: sync write, combinational read, sync clear
module seq_prog_mem #(
   parameter int AW = 3,
   parameter int IW = 21
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   localparam int DEPTH = 2 ** AW;

   logic [IW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         mem <= '{default: '0};
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/reg_alu_seq.sv
// rtl/reg_alu_seq.sv - replays a loaded control program onto the reg_alu bus (option: REG_ALU_SEQ_STEP_EN)
module reg_alu_seq
   import reg_alu_pkg::*;
#(
   parameter  int AW = AW_DEF,
   parameter  int DW = DW_DEF,
   parameter  int RA = RA_DEF,
   localparam int IW = iw_of(RA, DW)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [IW-1:0] load_data,
   input  logic          start,
   input  logic [AW:0]   prog_len,
`ifdef REG_ALU_SEQ_STEP_EN
   input  logic          step_mode,
   input  logic          step,
`endif
   output logic          busy,
   output logic          done,
   output logic [AW:0]   pc,
   output logic          sel,
   output logic          wr,
   output logic [1:0]    op,
   output logic [RA-1:0] rd_addr_a,
   output logic [RA-1:0] rd_addr_b,
   output logic [RA-1:0] wr_addr,
   output logic [DW-1:0] d_in
);

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(2 ** AW);

   seq_state_e    state, state_n;
   logic [AW:0]   pc_n, len_q, len_n, len_eff;
   logic          busy_n, done_n, adv, mem_we;
   logic [IW-1:0] ctrl_q, ctrl_n, mem_rdata;
   logic [AW-1:0] mem_raddr;

`ifdef REG_ALU_SEQ_STEP_EN
   assign adv = !step_mode || step;
`else
   assign adv = 1'b1;
`endif

   assign len_eff   = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
   assign mem_we    = load_en && (state == IDLE) && !start;
   assign mem_raddr = (state == RUN) ? pc[AW-1:0] : '0;

   seq_prog_mem #(.AW(AW), .IW(IW)) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_n = state;
      pc_n    = pc;
      len_n   = len_q;
      ctrl_n  = ctrl_q;
      busy_n  = busy;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (len_eff != '0) begin
                  state_n = RUN;
                  ctrl_n  = mem_rdata;
                  pc_n    = (AW + 1)'(1);
                  len_n   = len_eff;
                  busy_n  = 1'b1;
               end else begin
                  done_n  = 1'b1;
               end
            end
         end
         RUN: begin
            if (adv) begin
               if (pc < len_q) begin
                  ctrl_n = mem_rdata;
                  pc_n   = pc + (AW + 1)'(1);
               end else begin
                  // Zero the bus on exit so reg_alu never sees a stale wr
                  state_n = IDLE;
                  ctrl_n  = '0;
                  pc_n    = '0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         pc     <= '0;
         len_q  <= '0;
         ctrl_q <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         len_q  <= len_n;
         ctrl_q <= ctrl_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

   assign sel       = ctrl_q[sel_pos(RA, DW)];
   assign wr        = ctrl_q[wr_pos(RA, DW)];
   assign op        = ctrl_q[op_lsb(RA, DW) +: 2];
   assign rd_addr_a = ctrl_q[rda_lsb(RA, DW) +: RA];
   assign rd_addr_b = ctrl_q[rdb_lsb(RA, DW) +: RA];
   assign wr_addr   = ctrl_q[wa_lsb(DW) +: RA];
   assign d_in      = ctrl_q[DW-1:0];

endmodule

// File: tb/tb_reg_alu_seq.sv
// tb/tb_reg_alu_seq.sv - directed self-checking bench for reg_alu_seq
module tb_reg_alu_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic [2:0]  load_addr;
   logic [20:0] load_data;
   logic        start;
   logic [3:0]  prog_len;
   logic        busy, done, sel, wr;
   logic [3:0]  pc;
   logic [1:0]  op;
   logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
   logic [7:0]  d_in;
   logic [20:0] ctrl_word;
`ifdef REG_ALU_SEQ_STEP_EN
   logic        step_mode = 1'b0;
   logic        step = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   logic [20:0] exp_mem [8];

   always #5 clk = ~clk;

   reg_alu_seq dut (
      .clk       (clk),
      .reset     (reset),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .start     (start),
      .prog_len  (prog_len),
`ifdef REG_ALU_SEQ_STEP_EN
      .step_mode (step_mode),
      .step      (step),
`endif
      .busy      (busy),
      .done      (done),
      .pc        (pc),
      .sel       (sel),
      .wr        (wr),
      .op        (op),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .wr_addr   (wr_addr),
      .d_in      (d_in)
   );

   assign ctrl_word = {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in};

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_word(input logic [2:0] a, input logic [20:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, pc, ctrl_word} !== 27'd0) begin
         errors++;
         $display("FAIL reset_hold got busy=%0b done=%0b pc=%0d ctrl=%h want all 0", busy, done, pc, ctrl_word);
      end
      reset = 1'b0;
      tick();
      checks++;
      if ({busy, done, pc, ctrl_word} !== 27'd0) begin
         errors++;
         $display("FAIL reset_release got busy=%0b done=%0b pc=%0d ctrl=%h want all 0", busy, done, pc, ctrl_word);
      end
   endtask

   task automatic test_run4();
      exp_mem[0] = 21'h080306;
      exp_mem[1] = 21'h0A7F04;
      exp_mem[2] = 21'h0CFD02;
      exp_mem[3] = 21'h0E6905;
      for (int i = 0; i < 4; i++) load_word(3'(i), exp_mem[i]);
      prog_len = 4'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ctrl_word !== exp_mem[i] || busy !== 1'b1 || pc !== 4'(i + 1) || done !== 1'b0) begin
            errors++;
            $display("FAIL run4_word%0d got ctrl=%h busy=%0b pc=%0d done=%0b want ctrl=%h busy=1 pc=%0d done=0",
                     i, ctrl_word, busy, pc, done, exp_mem[i], i + 1);
         end
         tick();
      end
      checks++;
      if (ctrl_word !== 21'd0 || done !== 1'b1 || busy !== 1'b0 || pc !== 4'd0) begin
         errors++;
         $display("FAIL run4_done got ctrl=%h done=%0b busy=%0b pc=%0d want ctrl=0 done=1 busy=0 pc=0", ctrl_word, done, busy, pc);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL run4_done_width got done=%0b want 0", done);
      end
   endtask

   task automatic test_zero_len();
      prog_len = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || wr !== 1'b0 || pc !== 4'd0) begin
         errors++;
         $display("FAIL zero_len_done got done=%0b busy=%0b wr=%0b pc=%0d want done=1 busy=0 wr=0 pc=0", done, busy, wr, pc);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || wr !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_after got done=%0b busy=%0b wr=%0b want 0 0 0", done, busy, wr);
      end
   endtask

   task automatic test_blocked_load();
      prog_len = 4'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      load_en = 1'b1;
      load_addr = 3'd2;
      load_data = 21'h1FFFFF;
      tick();
      tick();
      load_en = 1'b0;
      tick();
      tick();
      tick();
      // load coincident with start must also be dropped
      load_en = 1'b1;
      load_addr = 3'd0;
      load_data = 21'h1FFFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      load_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ctrl_word !== exp_mem[i]) begin
            errors++;
            $display("FAIL blocked_load_word%0d got %h want %h", i, ctrl_word, exp_mem[i]);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL blocked_load_done got done=%0b want 1", done);
      end
      tick();
   endtask

   task automatic test_clamp();
      exp_mem[4] = 21'h112233;
      exp_mem[5] = 21'h1ABCDE;
      exp_mem[6] = 21'h054321;
      exp_mem[7] = 21'h15A5A5;
      for (int i = 4; i < 8; i++) load_word(3'(i), exp_mem[i]);
      prog_len = 4'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (ctrl_word !== exp_mem[i] || pc !== 4'(i + 1) || busy !== 1'b1) begin
            errors++;
            $display("FAIL clamp_word%0d got ctrl=%h pc=%0d busy=%0b want ctrl=%h pc=%0d busy=1",
                     i, ctrl_word, pc, busy, exp_mem[i], i + 1);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || ctrl_word !== 21'd0 || pc !== 4'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL clamp_done got done=%0b ctrl=%h pc=%0d busy=%0b want done=1 ctrl=0 pc=0 busy=0", done, ctrl_word, pc, busy);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      prog_len = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (ctrl_word !== exp_mem[0] || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first got ctrl=%h busy=%0b want ctrl=%h busy=1", ctrl_word, busy, exp_mem[0]);
      end
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done got done=%0b busy=%0b want done=1 busy=0", done, busy);
      end
      prog_len = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (ctrl_word !== exp_mem[0] || busy !== 1'b1 || pc !== 4'd1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_restart got ctrl=%h busy=%0b pc=%0d done=%0b want ctrl=%h busy=1 pc=1 done=0",
                  ctrl_word, busy, pc, done, exp_mem[0]);
      end
      tick();
      checks++;
      if (ctrl_word !== exp_mem[1] || pc !== 4'd2) begin
         errors++;
         $display("FAIL b2b_second got ctrl=%h pc=%0d want ctrl=%h pc=2", ctrl_word, pc, exp_mem[1]);
      end
      tick();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_done got done=%0b want 1", done);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      prog_len = 4'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if (pc !== 4'd2 || ctrl_word !== exp_mem[1]) begin
         errors++;
         $display("FAIL mid_reset_pre got pc=%0d ctrl=%h want pc=2 ctrl=%h", pc, ctrl_word, exp_mem[1]);
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({busy, done, pc, ctrl_word} !== 27'd0) begin
         errors++;
         $display("FAIL mid_reset_abort got busy=%0b done=%0b pc=%0d ctrl=%h want all 0", busy, done, pc, ctrl_word);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_no_done got done=%0b busy=%0b want 0 0", done, busy);
      end
      prog_len = 4'd8;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (ctrl_word !== 21'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_mem%0d got ctrl=%h busy=%0b want ctrl=0 busy=1", i, ctrl_word, busy);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_final_done got done=%0b want 1", done);
      end
      tick();
   endtask

   initial begin
      reset     = 1'b1;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      start     = 1'b0;
      prog_len  = '0;
      @(negedge clk);
      test_reset();
      test_run4();
      test_zero_len();
      test_blocked_load();
      test_clamp();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
